// File: rtl/npxl_pkg.sv
// Shared colours, FSM state type and counter-width helper for the NeoPixel VU strip.
package npxl_pkg;

  // GRB order: bits [23:16] green, [15:8] red, [7:0] blue.
  localparam logic [23:0] COL_OFF    = 24'h000000;
  localparam logic [23:0] COL_GREEN  = 24'h400000;
  localparam logic [23:0] COL_YELLOW = 24'h404000;
  localparam logic [23:0] COL_RED    = 24'h004000;
  localparam logic [23:0] COL_PEAK   = 24'h404040;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBitHi,
    StBitLo,
    StLatch
  } npxl_state_e;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int unsigned cnt_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/npxl_vu_strip_if.sv
// Request/status bundle between the level-detection logic and the VU strip driver.
interface npxl_vu_strip_if #(
  parameter int unsigned LEDS = 20,
  parameter int unsigned ADDR = 8
);
  localparam int unsigned CW = npxl_pkg::cnt_w(LEDS);

  logic            send;
  logic [ADDR-1:0] value;
  logic            rdy;
  logic [CW-1:0]   lit;
  logic [CW-1:0]   peak;

  modport master (output send, output value, input rdy, input lit, input peak);
  modport slave  (input send, input value, output rdy, output lit, output peak);
endinterface

// File: rtl/npxl_serializer.sv
// WS2812 bit-timing engine: fetches one 24-bit GRB pixel per LED and drives the data line.
module npxl_serializer
  import npxl_pkg::*;
#(
  parameter int unsigned LEDS     = 20,
  parameter int unsigned T0H_CYC  = 19,
  parameter int unsigned T1H_CYC  = 38,
  parameter int unsigned TBIT_CYC = 60,
  parameter int unsigned TRES_CYC = 2880
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [23:0]              pixel,
  output logic                     pix_req,
  output logic [cnt_w(LEDS)-1:0]   pix_idx,
  output logic                     done,
  output logic                     data
);
  localparam int unsigned CW = cnt_w(LEDS);
  localparam int unsigned TW = cnt_w((TBIT_CYC > TRES_CYC) ? TBIT_CYC : TRES_CYC);

  npxl_state_e     state_q, state_d;
  logic [TW-1:0]   cyc_q, cyc_d;
  logic [4:0]      bit_q, bit_d;
  logic [CW-1:0]   pix_q, pix_d;
  logic [23:0]     sr_q, sr_d;
  logic [TW-1:0]   hi_last;

  assign hi_last = sr_q[23] ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
  assign done    = (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    pix_d   = pix_q;
    sr_d    = sr_q;
    pix_req = 1'b0;
    pix_idx = pix_q + CW'(1);
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        pix_req = 1'b1;
        pix_idx = '0;
        sr_d    = pixel;
        cyc_d   = '0;
        bit_d   = '0;
        pix_d   = '0;
        state_d = StBitHi;
      end
      StBitHi: begin
        // The low phase keeps counting from here up to the full bit period.
        cyc_d = cyc_q + TW'(1);
        if (cyc_q == hi_last) state_d = StBitLo;
      end
      StBitLo: begin
        if (cyc_q == TW'(TBIT_CYC - 1)) begin
          cyc_d   = '0;
          state_d = StBitHi;
          if (bit_q == 5'd23) begin
            bit_d = '0;
            if (pix_q == CW'(LEDS - 1)) begin
              state_d = StLatch;
            end else begin
              pix_req = 1'b1;
              sr_d    = pixel;
              pix_d   = pix_q + CW'(1);
            end
          end else begin
            bit_d = bit_q + 5'd1;
            sr_d  = {sr_q[22:0], 1'b0};
          end
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      StLatch: begin
        if (cyc_q == TW'(TRES_CYC - 1)) begin
          cyc_d   = '0;
          state_d = StIdle;
        end else begin
          cyc_d = cyc_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      bit_q   <= '0;
      pix_q   <= '0;
      sr_q    <= '0;
      data    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      pix_q   <= pix_d;
      sr_q    <= sr_d;
      // Registered from the current state so the first rise lands two cycles after accept.
      data    <= (state_q == StBitHi);
    end
  end

endmodule

// File: rtl/npxl_vu_strip.sv
// VU-meter strip driver: level scaling, zone colouring and peak marker for a WS2812 chain.
// Peak hold/decay and the peak marker are built only when NPXL_PEAK_HOLD_EN is defined.
module npxl_vu_strip
  import npxl_pkg::*;
#(
  parameter int unsigned LEDS        = 20,
  parameter int unsigned ADDR        = 8,
  parameter int unsigned T0H_CYC     = 19,
  parameter int unsigned T1H_CYC     = 38,
  parameter int unsigned TBIT_CYC    = 60,
  parameter int unsigned TRES_CYC    = 2880,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  npxl_vu_strip_if.slave bus,
  output logic           o_npxl_data
);
  localparam int unsigned CW = cnt_w(LEDS);
  localparam int unsigned SW = ADDR + $clog2(LEDS) + 1;
  localparam logic [CW-1:0] GreenEnd  = CW'(LEDS * 6 / 10);
  localparam logic [CW-1:0] YellowEnd = CW'(LEDS * 17 / 20);

  if (LEDS < 2 || T0H_CYC == 0 || T1H_CYC <= T0H_CYC || TBIT_CYC <= T1H_CYC ||
      TRES_CYC == 0 || HOLD_FRAMES == 0) begin : g_bad_params
    $error("npxl_vu_strip: illegal parameter combination");
  end

  logic            accept, done, pix_req, frame_start;
  logic [CW-1:0]   pix_idx;
  logic [23:0]     pixel;
  logic [ADDR-1:0] value_q;
  logic [CW-1:0]   lit_q, lit_d, scaled;
  logic [SW-1:0]   prod;

  assign accept      = bus.send & done;
  assign bus.rdy     = done;
  assign bus.lit     = lit_q;
  assign frame_start = pix_req && (pix_idx == '0);

  always_comb begin
    prod   = (SW'(value_q) + SW'(1)) * SW'(LEDS);
    scaled = CW'(prod >> ADDR);
    lit_d  = frame_start ? scaled : lit_q;
  end

`ifdef NPXL_PEAK_HOLD_EN
  localparam int unsigned HW = cnt_w(HOLD_FRAMES);

  logic [CW-1:0] peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;

  // Once per frame: rising level grabs the peak, otherwise hold then decay by one.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    if (frame_start) begin
      if (scaled >= peak_q) begin
        peak_d = scaled;
        hold_d = HW'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else begin
        peak_d = peak_q - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      peak_q <= '0;
      hold_q <= '0;
    end else begin
      peak_q <= peak_d;
      hold_q <= hold_d;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif

  always_comb begin
    if (pix_idx < GreenEnd) begin
      pixel = COL_GREEN;
    end else if (pix_idx < YellowEnd) begin
      pixel = COL_YELLOW;
    end else begin
      pixel = COL_RED;
    end
    if (pix_idx >= lit_d) pixel = COL_OFF;
`ifdef NPXL_PEAK_HOLD_EN
    if (peak_d != '0 && pix_idx == peak_d - CW'(1)) pixel = COL_PEAK;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      value_q <= '0;
      lit_q   <= '0;
    end else begin
      if (accept) value_q <= bus.value;
      lit_q <= lit_d;
    end
  end

  npxl_serializer #(
    .LEDS    (LEDS),
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC),
    .TRES_CYC(TRES_CYC)
  ) u_ser (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (accept),
    .pixel  (pixel),
    .pix_req(pix_req),
    .pix_idx(pix_idx),
    .done   (done),
    .data   (o_npxl_data)
  );

endmodule

// File: tb/tb_npxl_vu_strip.sv
// Bench for npxl_vu_strip: random levels checked against a frame-level model of the strip.
module tb_npxl_vu_strip;
  localparam int LEDS = 20;
  localparam int ADDR = 8;
  localparam int T0H  = 2;
  localparam int T1H  = 3;
  localparam int TBIT = 5;
  localparam int TRES = 12;
  localparam int HOLD = 4;
  localparam int CW   = $clog2(LEDS + 1);
  localparam int NBITS  = LEDS * 24;
  localparam int NFRAME = 1 + NBITS * TBIT + TRES;
  localparam int MAXS   = 4096;
`ifdef NPXL_PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif
  localparam logic [23:0] C_GREEN  = 24'h400000;
  localparam logic [23:0] C_YELLOW = 24'h404000;
  localparam logic [23:0] C_RED    = 24'h004000;
  localparam logic [23:0] C_PEAK   = 24'h404040;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic npxl;

  npxl_vu_strip_if #(.LEDS(LEDS), .ADDR(ADDR)) bus ();

  npxl_vu_strip #(
    .LEDS(LEDS), .ADDR(ADDR), .T0H_CYC(T0H), .T1H_CYC(T1H), .TBIT_CYC(TBIT),
    .TRES_CYC(TRES), .HOLD_FRAMES(HOLD)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .bus        (bus),
    .o_npxl_data(npxl)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_lit = 0, m_peak = 0, m_hold = 0;
  logic [23:0] exp_col [LEDS];
  logic wave [MAXS];
  int n_low;

  // Frame-level model: scale, update peak, then paint every LED.
  task automatic model_frame(input int v);
    int lit;
    lit = ((v + 1) * LEDS) / (1 << ADDR);
    m_lit = lit;
    if (PK) begin
      if (lit >= m_peak) begin
        m_peak = lit;
        m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_peak--;
      end
    end
    for (int i = 0; i < LEDS; i++) begin
      if (i >= lit) exp_col[i] = 24'h0;
      else if (i < (LEDS * 6) / 10) exp_col[i] = C_GREEN;
      else if (i < (LEDS * 17) / 20) exp_col[i] = C_YELLOW;
      else exp_col[i] = C_RED;
      if (PK && m_peak > 0 && i == m_peak - 1) exp_col[i] = C_PEAK;
    end
  endtask

  // Samples (taken 1 time unit after each edge since accept) that differ from the ideal line.
  function automatic int wave_errs();
    int errs, b, ph, led, bi;
    logic e;
    errs = 0;
    for (int k = 0; k <= n_low && k < MAXS; k++) begin
      e = 1'b0;
      if (k >= 2 && k < 2 + NBITS * TBIT) begin
        b   = (k - 2) / TBIT;
        ph  = (k - 2) % TBIT;
        led = b / 24;
        bi  = 23 - (b % 24);
        e   = (ph < (exp_col[led][bi] ? T1H : T0H));
      end
      if (wave[k] !== e) errs++;
    end
    return errs;
  endfunction

  // Request one frame and record the line until rdy returns; optional ignored pulse at pulse_at.
  task automatic run_frame(input logic [ADDR-1:0] v, input int pulse_at);
    @(negedge clk);
    bus.send  = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    wave[0] = npxl;
    n_low = bus.rdy ? 0 : 1;
    if (!bus.rdy) begin
      for (int k = 1; k < MAXS; k++) begin
        @(posedge clk);
        #1;
        wave[k] = npxl;
        bus.send = 1'b0;
        if (bus.rdy) break;
        n_low++;
        if (k == pulse_at) begin
          bus.send  = 1'b1;
          bus.value = ~v;
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.send  = 1'b0;
    bus.value = '0;
    rst_n     = 1'b0;
    #2;
    n_cmp++; if (bus.rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", bus.rdy); end
    n_cmp++; if (npxl !== 1'b0) begin n_bad++; $display("FAIL reset_data got %b want 0", npxl); end
    n_cmp++; if (bus.lit !== CW'(0)) begin n_bad++; $display("FAIL reset_lit got %0d want 0", bus.lit); end
    n_cmp++; if (bus.peak !== CW'(0)) begin n_bad++; $display("FAIL reset_peak got %0d want 0", bus.peak); end
    bus.send = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.rdy !== 1'b1 || npxl !== 1'b0) begin
      n_bad++; $display("FAIL reset_hold rdy=%b data=%b want rdy=1 data=0", bus.rdy, npxl);
    end
    bus.send = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_levels();
    logic [ADDR-1:0] seq [$];
    int e;
    seq = {8'd127, 8'd255};
    repeat (9) seq.push_back(8'd0);
    repeat (4) seq.push_back(8'($urandom_range(0, 255)));
    foreach (seq[j]) begin
      run_frame(seq[j], -1);
      model_frame(int'(seq[j]));
      e = wave_errs();
      n_cmp++; if (n_low !== NFRAME) begin
        n_bad++; $display("FAIL lvl_rdy_low frame %0d got %0d want %0d", j, n_low, NFRAME);
      end
      n_cmp++; if (e !== 0) begin
        n_bad++; $display("FAIL lvl_wave frame %0d v=%0d got %0d bad samples want 0", j, seq[j], e);
      end
      n_cmp++; if (bus.lit !== CW'(m_lit)) begin
        n_bad++; $display("FAIL lvl_lit frame %0d got %0d want %0d", j, bus.lit, m_lit);
      end
      n_cmp++; if (bus.peak !== CW'(m_peak)) begin
        n_bad++; $display("FAIL lvl_peak frame %0d got %0d want %0d", j, bus.peak, m_peak);
      end
    end
  endtask

  task automatic test_ignored_send();
    logic [ADDR-1:0] v;
    int idle_bad;
    v = 8'($urandom_range(1, 255));
    run_frame(v, 700);
    model_frame(int'(v));
    n_cmp++; if (n_low !== NFRAME) begin
      n_bad++; $display("FAIL ign_rdy_low got %0d want %0d", n_low, NFRAME);
    end
    n_cmp++; if (wave_errs() !== 0) begin
      n_bad++; $display("FAIL ign_wave got %0d bad samples want 0", wave_errs());
    end
    n_cmp++; if (bus.lit !== CW'(m_lit)) begin
      n_bad++; $display("FAIL ign_lit got %0d want %0d", bus.lit, m_lit);
    end
    idle_bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.rdy !== 1'b1 || npxl !== 1'b0) idle_bad++;
    end
    n_cmp++; if (idle_bad !== 0) begin
      n_bad++; $display("FAIL ign_no_extra got %0d busy cycles want 0", idle_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [ADDR-1:0] v;
    v = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus.send  = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    repeat (2 + 200 * TBIT) @(posedge clk);
    #2;
    n_cmp++; if (npxl !== 1'b1) begin n_bad++; $display("FAIL mid_bit200_high got %b want 1", npxl); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (npxl !== 1'b0) begin n_bad++; $display("FAIL mid_rst_data got %b want 0", npxl); end
    n_cmp++; if (bus.rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy got %b want 1", bus.rdy); end
    n_cmp++; if (bus.peak !== CW'(0)) begin
      n_bad++; $display("FAIL mid_rst_peak got %0d want 0", bus.peak);
    end
    m_lit = 0; m_peak = 0; m_hold = 0;
    @(negedge clk);
    rst_n = 1'b1;
    v = 8'($urandom_range(0, 255));
    run_frame(v, -1);
    model_frame(int'(v));
    n_cmp++; if (n_low !== NFRAME) begin
      n_bad++; $display("FAIL mid_next_rdy_low got %0d want %0d", n_low, NFRAME);
    end
    n_cmp++; if (wave_errs() !== 0) begin
      n_bad++; $display("FAIL mid_next_wave got %0d bad samples want 0", wave_errs());
    end
    n_cmp++; if (bus.peak !== CW'(m_peak)) begin
      n_bad++; $display("FAIL mid_next_peak got %0d want %0d", bus.peak, m_peak);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR-1:0] v1, v2;
    int n;
    v1 = 8'($urandom_range(0, 255));
    v2 = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus.send  = 1'b1;
    bus.value = v1;
    @(posedge clk);
    #1;
    bus.value = v2;
    model_frame(int'(v1));
    for (int k = 0; k < MAXS; k++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) break;
    end
    n_cmp++; if (bus.lit !== CW'(m_lit)) begin
      n_bad++; $display("FAIL b2b_lit1 got %0d want %0d", bus.lit, m_lit);
    end
    @(posedge clk);
    #1;
    bus.send = 1'b0;
    n_cmp++; if (bus.rdy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_retrigger rdy got %b want 0", bus.rdy);
    end
    model_frame(int'(v2));
    n = 1;
    for (int k = 0; k < MAXS; k++) begin
      @(posedge clk);
      #1;
      if (bus.rdy) break;
      n++;
    end
    n_cmp++; if (n !== NFRAME) begin
      n_bad++; $display("FAIL b2b_rdy_low got %0d want %0d", n, NFRAME);
    end
    n_cmp++; if (bus.lit !== CW'(m_lit) || bus.peak !== CW'(m_peak)) begin
      n_bad++; $display("FAIL b2b_lit2_peak got %0d/%0d want %0d/%0d",
                        bus.lit, bus.peak, m_lit, m_peak);
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_ignored_send();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
